// File: rtl/avl_sample_fifo_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : avl_sample_fifo_slave_if
// Description : Avalon-MM bus bundle between software initiator and the
//               sample FIFO responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface avl_sample_fifo_slave_if;
  logic [13:0] avl_address_i;
  logic [3:0]  avl_byteenable_i;
  logic        avl_write_i;
  logic [15:0] avl_writedata_i;
  logic        avl_read_i;
  logic        avl_readdatavalid_o;
  logic [15:0] avl_readdata_o;
  logic        avl_waitrequest_o;
  logic        avl_irq_o;

  modport slave (
    input  avl_address_i, avl_byteenable_i, avl_write_i, avl_writedata_i, avl_read_i,
    output avl_readdatavalid_o, avl_readdata_o, avl_waitrequest_o, avl_irq_o
  );

  modport master (
    output avl_address_i, avl_byteenable_i, avl_write_i, avl_writedata_i, avl_read_i,
    input  avl_readdatavalid_o, avl_readdata_o, avl_waitrequest_o, avl_irq_o
  );
endinterface
`default_nettype wire

// File: rtl/avl_sample_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : avl_sample_fifo_slave
// Description : Avalon-MM responder capturing raw samples into a FIFO with
//               threshold/overflow IRQ. Optional macro AVL_SAMPLE_TIMESTAMP_EN
//               adds a per-entry 16-bit cycle timestamp readable at address 6.
// Revision    : 1.0 - initial release
// ============================================================================
module avl_sample_fifo_slave #(
  parameter int          FIFO_DEPTH = 64,
  parameter logic [15:0] ID_VALUE   = 16'h5F1F
) (
  input  logic                   avl_clk_i,
  input  logic                   avl_reset_i,
  avl_sample_fifo_slave_if.slave avl,
  input  logic [15:0]            sample_i,
  input  logic                   sample_valid_i
);
  localparam int            AW     = $clog2(FIFO_DEPTH);
  localparam int            LW     = AW + 1;
  localparam logic [LW-1:0] C_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic            acq_en_q, acq_en_d, irq_en_q, irq_en_d;
  logic [15:0]     thresh_q, thresh_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, pend_q, pend_d;
  logic            irq_q, irq_d, rvalid_q, rvalid_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            wait_req, rd_acc, wr_acc, is_pop, pop_ok, push, drop, flush;
  logic            empty, full, crossing;
  logic [15:0]     ts_head, rd_mux;
  logic            unused_be;

  assign unused_be = ^avl.avl_byteenable_i[3:2];

  assign wait_req = (state_q == ST_INIT);
  assign empty    = (count_q == '0);
  assign full     = (count_q == C_FULL);

  // A simultaneous read wins; the write in that cycle is dropped.
  assign rd_acc = avl.avl_read_i & ~wait_req;
  assign wr_acc = avl.avl_write_i & ~avl.avl_read_i & ~wait_req;
  assign is_pop = rd_acc && (avl.avl_address_i == 14'd5);
  assign pop_ok = is_pop & ~empty;
  assign flush  = wr_acc && (avl.avl_address_i == 14'd1) && avl.avl_byteenable_i[0]
                  && avl.avl_writedata_i[2];
  assign push   = sample_valid_i & acq_en_q & (~full | pop_ok) & ~flush;
  assign drop   = sample_valid_i & acq_en_q & full & ~pop_ok & ~flush;

  always_comb begin
    state_d  = ST_READY;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acq_en_d = acq_en_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    pend_d   = pend_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + LW'(push) - LW'(pop_ok);
    end

    if (wr_acc) begin
      case (avl.avl_address_i)
        14'd1: if (avl.avl_byteenable_i[0]) begin
          acq_en_d = avl.avl_writedata_i[0];
          irq_en_d = avl.avl_writedata_i[1];
        end
        14'd2: if (avl.avl_byteenable_i[0]) begin
          if (avl.avl_writedata_i[3]) ovf_d  = 1'b0;
          if (avl.avl_writedata_i[4]) pend_d = 1'b0;
          if (avl.avl_writedata_i[5]) unf_d  = 1'b0;
        end
        14'd4: begin
          if (avl.avl_byteenable_i[0]) thresh_d[7:0]  = avl.avl_writedata_i[7:0];
          if (avl.avl_byteenable_i[1]) thresh_d[15:8] = avl.avl_writedata_i[15:8];
        end
        default: ;
      endcase
    end

    // New events take priority over a W1C clear landing in the same cycle.
    crossing = (thresh_q != 16'd0) && (16'(count_q) < thresh_q) && (16'(count_d) >= thresh_q);
    if (drop)              ovf_d  = 1'b1;
    if (is_pop && empty)   unf_d  = 1'b1;
    if (crossing || drop)  pend_d = 1'b1;

    irq_d = pend_d & irq_en_d;
  end

  always_comb begin
    rd_mux = 16'd0;
    case (avl.avl_address_i)
      14'd0:   rd_mux = ID_VALUE;
      14'd1:   rd_mux = {14'd0, irq_en_q, acq_en_q};
      14'd2:   rd_mux = {10'd0, unf_q, pend_q, ovf_q, full, empty, acq_en_q};
      14'd3:   rd_mux = 16'(count_q);
      14'd4:   rd_mux = thresh_q;
      14'd5:   rd_mux = empty ? 16'd0 : mem_q[rd_ptr_q];
      14'd6:   rd_mux = ts_head;
      default: rd_mux = 16'd0;
    endcase
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? rd_mux : rdata_q;
  end

  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) begin
      state_q  <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acq_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= 16'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acq_en_q <= acq_en_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge avl_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= sample_i;
  end

`ifdef AVL_SAMPLE_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_cnt_d;
  logic [15:0] ts_mem_q [FIFO_DEPTH];

  assign ts_cnt_d = ts_cnt_q + 16'd1;
  assign ts_head  = empty ? 16'd0 : ts_mem_q[rd_ptr_q];

  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) ts_cnt_q <= 16'd0;
    else             ts_cnt_q <= ts_cnt_d;
  end

  always_ff @(posedge avl_clk_i) begin
    if (push) ts_mem_q[wr_ptr_q] <= ts_cnt_q;
  end
`else
  assign ts_head = 16'd0;
`endif

  assign avl.avl_waitrequest_o   = wait_req;
  assign avl.avl_readdatavalid_o = rvalid_q;
  assign avl.avl_readdata_o      = rdata_q;
  assign avl.avl_irq_o           = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_avl_sample_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_avl_sample_fifo_slave
// Description : Self-checking bench for avl_sample_fifo_slave with a
//               queue-based reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avl_sample_fifo_slave;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] cyc;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  avl_sample_fifo_slave_if bus ();

  avl_sample_fifo_slave #(.FIFO_DEPTH(DEPTH), .ID_VALUE(16'h5F1F)) dut (
    .avl_clk_i      (clk),
    .avl_reset_i    (rst),
    .avl            (bus),
    .sample_i       (sample),
    .sample_valid_i (sample_valid)
  );

  // Cycle count since reset, matching the timestamp the DUT should capture.
  always @(posedge clk) cyc <= rst ? 16'd0 : cyc + 16'd1;

  // Reference model state.
  logic [15:0] mq[$];
  logic [15:0] mts[$];
  bit          m_acq, m_irqen, m_ovf, m_unf, m_pend;
  logic [15:0] m_th;

  function automatic void model_reset();
    mq.delete(); mts.delete();
    m_acq = 0; m_irqen = 0; m_ovf = 0; m_unf = 0; m_pend = 0; m_th = 16'd0;
  endfunction

  function automatic logic [15:0] model_read(input logic [13:0] addr);
    case (addr)
      14'd0: return 16'h5F1F;
      14'd1: return {14'd0, m_irqen, m_acq};
      14'd2: return {10'd0, m_unf, m_pend, m_ovf, mq.size() == DEPTH, mq.size() == 0, m_acq};
      14'd3: return 16'(mq.size());
      14'd4: return m_th;
      14'd5: return (mq.size() > 0) ? mq[0] : 16'd0;
`ifdef AVL_SAMPLE_TIMESTAMP_EN
      14'd6: return (mq.size() > 0) ? mts[0] : 16'd0;
`endif
      default: return 16'd0;
    endcase
  endfunction

  function automatic void model_apply(input bit rd, input bit wr, input logic [13:0] addr,
                                      input logic [15:0] wd, input logic [3:0] be,
                                      input bit sv, input logic [15:0] sd, input logic [15:0] t);
    bit wr_eff;
    int old_lvl;
    wr_eff = wr && !rd;
    if (wr_eff && addr == 14'd2 && be[0]) begin
      if (wd[3]) m_ovf = 0;
      if (wd[4]) m_pend = 0;
      if (wd[5]) m_unf = 0;
    end
    if (wr_eff && addr == 14'd1 && be[0] && wd[2]) begin
      mq.delete(); mts.delete();
    end else begin
      old_lvl = mq.size();
      if (rd && addr == 14'd5) begin
        if (mq.size() > 0) begin
          void'(mq.pop_front()); void'(mts.pop_front());
        end else m_unf = 1;
      end
      if (sv && m_acq) begin
        if (mq.size() < DEPTH) begin mq.push_back(sd); mts.push_back(t); end
        else begin m_ovf = 1; m_pend = 1; end
      end
      if (m_th != 0 && old_lvl < int'(m_th) && mq.size() >= int'(m_th)) m_pend = 1;
    end
    if (wr_eff && addr == 14'd1 && be[0]) begin m_acq = wd[0]; m_irqen = wd[1]; end
    if (wr_eff && addr == 14'd4) begin
      if (be[0]) m_th[7:0]  = wd[7:0];
      if (be[1]) m_th[15:8] = wd[15:8];
    end
  endfunction

  // One bus/sample cycle; returns captured read data and the model's expectation.
  task automatic op(input bit rd, input bit wr, input logic [13:0] addr, input logic [15:0] wd,
                    input logic [3:0] be, input bit sv, input logic [15:0] sd,
                    output logic [15:0] act, output logic act_v, output logic [15:0] exp);
    logic [15:0] t;
    for (int k = 0; k < 8 && bus.avl_waitrequest_o !== 1'b0; k++) @(negedge clk);
    if (bus.avl_waitrequest_o !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL waitrequest_timeout: waitrequest=%b required 0", bus.avl_waitrequest_o);
    end
    exp = model_read(addr);
    t   = cyc;
    bus.avl_read_i = rd; bus.avl_write_i = wr; bus.avl_address_i = addr;
    bus.avl_writedata_i = wd; bus.avl_byteenable_i = be;
    sample_valid = sv; sample = sd;
    @(posedge clk);
    @(negedge clk);
    act = bus.avl_readdata_o; act_v = bus.avl_readdatavalid_o;
    bus.avl_read_i = 0; bus.avl_write_i = 0; sample_valid = 0;
    model_apply(rd, wr, addr, wd, be, sv, sd, t);
  endtask

  logic [15:0] a, e;
  logic        v;

  task automatic test_reset();
    rst = 1;
    bus.avl_read_i = 0; bus.avl_write_i = 0; bus.avl_address_i = '0;
    bus.avl_writedata_i = '0; bus.avl_byteenable_i = 4'hF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.avl_waitrequest_o !== 1'b1 || bus.avl_readdatavalid_o !== 1'b0 ||
        bus.avl_irq_o !== 1'b0 || bus.avl_readdata_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr=%b rv=%b irq=%b rd=%h required 1 0 0 0000",
               bus.avl_waitrequest_o, bus.avl_readdatavalid_o, bus.avl_irq_o, bus.avl_readdata_o);
    end
    rst = 0;
    model_reset();
    #1;
    n_checks++;
    if (bus.avl_waitrequest_o !== 1'b1) begin
      n_fail++; $display("FAIL init_wait: waitrequest=%b required 1", bus.avl_waitrequest_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.avl_waitrequest_o !== 1'b0) begin
      n_fail++; $display("FAIL ready_wait: waitrequest=%b required 0", bus.avl_waitrequest_o);
    end
  endtask

  task automatic test_id();
    op(1, 0, 14'd0, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (v !== 1'b1 || a !== e) begin
      n_fail++; $display("FAIL id_read: valid=%b data=%h required 1 %h", v, a, e);
    end
    @(negedge clk);
    n_checks++;
    if (bus.avl_readdatavalid_o !== 1'b0 || bus.avl_readdata_o !== 16'h5F1F) begin
      n_fail++; $display("FAIL rdata_hold: valid=%b data=%h required 0 5f1f",
                         bus.avl_readdatavalid_o, bus.avl_readdata_o);
    end
  endtask

  task automatic test_fifo_order();
    logic [15:0] vals [3];
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
    op(0, 1, 14'd1, 16'h0001, 4'hF, 0, 0, a, v, e);
    for (int i = 0; i < 3; i++) op(0, 0, 14'd0, 0, 4'hF, 1, vals[i], a, v, e);
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 14'd5, 0, 4'hF, 0, 0, a, v, e);
      n_checks++;
      if (a !== e || a !== vals[i]) begin
        n_fail++; $display("FAIL pop_order[%0d]: data=%0d required %0d", i, a, vals[i]);
      end
    end
    op(1, 0, 14'd3, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL level_empty: level=%0d required %0d", a, e); end
    op(1, 0, 14'd2, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e || a[1] !== 1'b1) begin
      n_fail++; $display("FAIL status_empty: status=%h required %h", a, e);
    end
  endtask

  task automatic test_threshold_irq();
    op(0, 1, 14'd4, 16'd4, 4'hF, 0, 0, a, v, e);
    op(0, 1, 14'd1, 16'd3, 4'hF, 0, 0, a, v, e);
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 14'd0, 0, 4'hF, 1, 16'(100 + i), a, v, e);
      n_checks++;
      if (bus.avl_irq_o !== (m_pend & m_irqen) || bus.avl_irq_o !== (i == 3)) begin
        n_fail++; $display("FAIL thresh_irq[%0d]: irq=%b required %b", i, bus.avl_irq_o, i == 3);
      end
    end
    op(0, 1, 14'd2, 16'h0010, 4'h1, 0, 0, a, v, e);
    n_checks++;
    if (bus.avl_irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_w1c: irq=%b required 0", bus.avl_irq_o);
    end
    op(0, 0, 14'd0, 0, 4'hF, 1, 16'd105, a, v, e);
    n_checks++;
    if (bus.avl_irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_no_recross: irq=%b required 0", bus.avl_irq_o);
    end
  endtask

  task automatic test_overflow();
    int bad;
    op(0, 1, 14'd1, 16'h0004, 4'h1, 0, 0, a, v, e);
    op(0, 1, 14'd2, 16'h0038, 4'h1, 0, 0, a, v, e);
    op(0, 1, 14'd4, 16'd0, 4'h3, 0, 0, a, v, e);
    op(0, 1, 14'd1, 16'h0003, 4'h1, 0, 0, a, v, e);
    for (int i = 0; i < DEPTH; i++) op(0, 0, 14'd0, 0, 4'hF, 1, 16'(1000 + i), a, v, e);
    op(0, 0, 14'd0, 0, 4'hF, 1, 16'd99, a, v, e);
    op(1, 0, 14'd3, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e || a !== 16'(DEPTH)) begin
      n_fail++; $display("FAIL full_level: level=%0d required %0d", a, DEPTH);
    end
    op(1, 0, 14'd2, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e || a[3] !== 1'b1 || a[2] !== 1'b1 || bus.avl_irq_o !== 1'b1) begin
      n_fail++; $display("FAIL overflow_flags: status=%h irq=%b required %h 1", a, bus.avl_irq_o, e);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op(1, 0, 14'd5, 0, 4'hF, 0, 0, a, v, e);
      if (a !== e || a === 16'd99) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL drain_values: bad=%0d required 0", bad); end
    op(1, 0, 14'd5, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== 16'd0) begin n_fail++; $display("FAIL underflow_data: data=%h required 0000", a); end
    op(1, 0, 14'd2, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e || a[5] !== 1'b1) begin
      n_fail++; $display("FAIL underflow_flag: status=%h required %h", a, e);
    end
  endtask

  task automatic test_acq_flush();
    op(0, 1, 14'd1, 16'h0001, 4'h1, 0, 0, a, v, e);
    for (int i = 0; i < 3; i++) op(0, 0, 14'd0, 0, 4'hF, 1, 16'(7 * i), a, v, e);
    op(0, 1, 14'd1, 16'h0000, 4'h1, 0, 0, a, v, e);
    for (int i = 0; i < 6; i++) op(0, 0, 14'd0, 0, 4'hF, i[0], 16'hBEEF, a, v, e);
    op(1, 0, 14'd3, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e || a !== 16'd3) begin
      n_fail++; $display("FAIL acq_off_level: level=%0d required 3", a);
    end
    op(0, 1, 14'd1, 16'h0004, 4'h1, 0, 0, a, v, e);
    op(1, 0, 14'd3, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== 16'd0) begin n_fail++; $display("FAIL flush_level: level=%0d required 0", a); end
  endtask

  task automatic test_byteenable_and_collision();
    op(0, 1, 14'd4, 16'h1234, 4'h3, 0, 0, a, v, e);
    op(0, 1, 14'd4, 16'hABCD, 4'h2, 0, 0, a, v, e);
    op(1, 1, 14'd4, 16'h5555, 4'hF, 0, 0, a, v, e);
    op(1, 0, 14'd4, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== e || a !== 16'hAB34) begin
      n_fail++; $display("FAIL byteenable_rw: thresh=%h required ab34", a);
    end
    op(0, 1, 14'd4, 16'h0000, 4'h3, 0, 0, a, v, e);
    op(0, 1, 14'd1, 16'h0001, 4'h1, 0, 0, a, v, e);
    op(1, 0, 14'd5, 0, 4'hF, 1, 16'h4242, a, v, e);
    n_checks++;
    if (a !== 16'd0 || v !== 1'b1) begin
      n_fail++; $display("FAIL empty_push_pop: data=%h valid=%b required 0000 1", a, v);
    end
    op(1, 0, 14'd3, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== 16'd1) begin n_fail++; $display("FAIL empty_push_pop_level: level=%0d required 1", a); end
  endtask

  task automatic test_timestamp();
    logic [15:0] t;
    op(0, 1, 14'd1, 16'h0005, 4'h1, 0, 0, a, v, e);
    repeat (3) @(negedge clk);
    t = cyc;
    op(0, 0, 14'd0, 0, 4'hF, 1, 16'h7777, a, v, e);
    op(1, 0, 14'd6, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
`ifdef AVL_SAMPLE_TIMESTAMP_EN
    if (a !== e || a !== t) begin
      n_fail++; $display("FAIL timestamp: ts=%h required %h", a, t);
    end
`else
    if (a !== 16'd0 || a !== e) begin
      n_fail++; $display("FAIL timestamp_off: ts=%h required 0000 (t=%h)", a, t);
    end
`endif
  endtask

  task automatic test_random();
    int bad;
    int irq_bad;
    logic [13:0] addr;
    logic [15:0] wd;
    bit rd, wr;
    bad = 0; irq_bad = 0;
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 8))
        0: addr = 14'd0; 1: addr = 14'd1; 2: addr = 14'd2; 3: addr = 14'd3;
        4: addr = 14'd4; 5, 6: addr = 14'd5; 7: addr = 14'd6; default: addr = 14'h3FFF;
      endcase
      wd = 16'($urandom);
      if (addr == 14'd1) wd[2] = ($urandom_range(0, 7) == 0);
      if (addr == 14'd1 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if (addr == 14'd4) wd = 16'($urandom_range(0, 10));
      op(rd, wr, addr, wd, 4'($urandom), $urandom_range(0, 1) == 1, 16'($urandom), a, v, e);
      if (v !== rd || (rd && a !== e)) begin
        bad++;
        if (bad < 4) $display("FAIL random_read[%0d]: addr=%0d data=%h valid=%b required %h %b",
                              i, addr, a, v, e, rd);
      end
      if (bus.avl_irq_o !== (m_pend & m_irqen)) irq_bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL random_reads: errors=%0d required 0", bad); end
    n_checks++;
    if (irq_bad != 0) begin n_fail++; $display("FAIL random_irq: errors=%0d required 0", irq_bad); end
  endtask

  task automatic test_reset_mid();
    op(0, 1, 14'd1, 16'h0003, 4'h1, 0, 0, a, v, e);
    op(0, 0, 14'd0, 0, 4'hF, 1, 16'h1111, a, v, e);
    bus.avl_read_i = 1; bus.avl_address_i = 14'd0;
    @(posedge clk);
    @(negedge clk);
    bus.avl_read_i = 0;
    rst = 1;
    @(negedge clk);
    n_checks++;
    if (bus.avl_readdatavalid_o !== 1'b0 || bus.avl_waitrequest_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_outputs: rv=%b wr=%b required 0 1",
                         bus.avl_readdatavalid_o, bus.avl_waitrequest_o);
    end
    rst = 0;
    model_reset();
    op(1, 0, 14'd3, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== 16'd0 || a !== e) begin n_fail++; $display("FAIL reset_mid_level: level=%0d required 0", a); end
    op(1, 0, 14'd1, 0, 4'hF, 0, 0, a, v, e);
    n_checks++;
    if (a !== 16'd0) begin n_fail++; $display("FAIL reset_mid_ctrl: ctrl=%h required 0000", a); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_id();
    test_fifo_order();
    test_threshold_irq();
    test_overflow();
    test_acq_flush();
    test_byteenable_and_collision();
    test_timestamp();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
